// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the 8-bit CPU core.
//
// Fetches one instruction per pass (FETCH -> DECODE -> EXECUTE -> WRITEBACK),
// decodes it into register-file addresses, an ALU function select and the
// register-file write strobe, and owns the program counter. HALT (opcode 0xF)
// parks the core until reset.
//
// Optional feature: define CPU_SEQ_FETCH_TIMEOUT_EN to add a fetch wait counter.
// When FETCH waits FETCH_TIMEOUT cycles without a handshake the core parks in
// FAULT. Without the macro FETCH waits indefinitely and fault is tied to 0.
//
// Ports:
//   clk           in   core clock, rising edge
//   rst           in   synchronous active-high reset
//   instr[7:0]    in   instruction word, meaningful when instr_valid = 1
//   instr_valid   in   instruction memory handshake (only honoured in FETCH)
//   alu_zero      in   ALU zero flag, sampled at the EXECUTE edge
//   pc[7:0]       out  program counter / instruction address
//   instr_req     out  fetch request, high only in FETCH
//   reg_dest[1:0] out  register-file destination address
//   reg_src1      out  register-file operand 1 address
//   reg_src2      out  register-file operand 2 address
//   write_enable  out  register-file write strobe, one cycle in WRITEBACK
//   alu_op[2:0]   out  ALU function select
//   halted        out  core stopped in HALT or FAULT
//   fault         out  fetch timeout occurred
module cpu_sequencer #(
   parameter int unsigned FETCH_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] instr,
   input  logic       instr_valid,
   input  logic       alu_zero,
   output logic [7:0] pc,
   output logic       instr_req,
   output logic [1:0] reg_dest,
   output logic       reg_src1,
   output logic       reg_src2,
   output logic       write_enable,
   output logic [2:0] alu_op,
   output logic       halted,
   output logic       fault
);

   typedef enum logic [2:0] {
      StFetch,
      StDecode,
      StExecute,
      StWriteback,
      StHalt
`ifdef CPU_SEQ_FETCH_TIMEOUT_EN
      ,
      StFault
`endif
   } state_e;

   localparam logic [3:0] OpBz   = 4'h8;
   localparam logic [3:0] OpHalt = 4'hF;

   state_e      state_q;
   logic [7:0]  pc_q;
   logic [7:0]  pc_d;
   logic [7:0]  ir_q;
   logic        taken_q;
   logic        instr_req_q;
   logic        we_q;
   logic [2:0]  alu_op_q;
   logic        halted_q;
   logic [3:0]  ir_op;
   logic [7:0]  br_off;

   assign ir_op  = ir_q[7:4];
   assign br_off = {{4{ir_q[3]}}, ir_q[3:0]};

   function automatic logic [2:0] alu_op_of(input logic [3:0] op);
      case (op)
         4'h1:    return 3'd0;  // ADD
         4'h2:    return 3'd1;  // SUB
         4'h3:    return 3'd2;  // AND
         4'h4:    return 3'd3;  // OR
         4'h5:    return 3'd4;  // XOR
         4'h6:    return 3'd5;  // MOV (pass operand 1)
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic writes_rf(input logic [3:0] op);
      return (op >= 4'h1) && (op <= 4'h6);
   endfunction

   // Next PC taken at the WRITEBACK exit; wraps modulo 256.
   always_comb begin
      pc_d = pc_q + 8'd1;
      if ((ir_op == OpBz) && taken_q) begin
         pc_d = pc_q + br_off;
      end
   end

`ifdef CPU_SEQ_FETCH_TIMEOUT_EN
   localparam logic [3:0] TimeoutLast = 4'(FETCH_TIMEOUT - 1);

   logic [3:0] wait_cnt_q;
   logic       fault_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^FETCH_TIMEOUT;
`endif

   // Outputs are registered for the state being entered, so each one is a
   // clean per-state decode with no glitch across state boundaries.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StFetch;
         pc_q        <= 8'h00;
         ir_q        <= 8'h00;
         taken_q     <= 1'b0;
         instr_req_q <= 1'b1;
         we_q        <= 1'b0;
         alu_op_q    <= 3'd0;
         halted_q    <= 1'b0;
`ifdef CPU_SEQ_FETCH_TIMEOUT_EN
         wait_cnt_q  <= 4'd0;
         fault_q     <= 1'b0;
`endif
      end else begin
         we_q <= 1'b0;
         unique case (state_q)
            StFetch: begin
               if (instr_valid) begin
                  ir_q        <= instr;
                  alu_op_q    <= alu_op_of(instr[7:4]);
                  instr_req_q <= 1'b0;
                  state_q     <= StDecode;
               end
`ifdef CPU_SEQ_FETCH_TIMEOUT_EN
               else if (wait_cnt_q == TimeoutLast) begin
                  instr_req_q <= 1'b0;
                  halted_q    <= 1'b1;
                  fault_q     <= 1'b1;
                  state_q     <= StFault;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 4'd1;
               end
`endif
            end
            StDecode: begin
               state_q <= StExecute;
            end
            StExecute: begin
               // Branch condition is captured here and held through WRITEBACK.
               taken_q <= alu_zero;
               if (ir_op == OpHalt) begin
                  halted_q <= 1'b1;
                  alu_op_q <= 3'd0;
                  state_q  <= StHalt;
               end else begin
                  we_q    <= writes_rf(ir_op);
                  state_q <= StWriteback;
               end
            end
            StWriteback: begin
               pc_q        <= pc_d;
               alu_op_q    <= 3'd0;
               instr_req_q <= 1'b1;
`ifdef CPU_SEQ_FETCH_TIMEOUT_EN
               wait_cnt_q  <= 4'd0;
`endif
               state_q     <= StFetch;
            end
            StHalt: begin
               state_q <= StHalt;
            end
`ifdef CPU_SEQ_FETCH_TIMEOUT_EN
            StFault: begin
               state_q <= StFault;
            end
`endif
            default: begin
               state_q <= StFetch;
            end
         endcase
      end
   end

   // Reset is also an output mask: a write pending in WRITEBACK is dropped
   // when reset lands on that cycle.
   assign pc           = pc_q;
   assign instr_req    = instr_req_q & ~rst;
   assign write_enable = we_q & ~rst;
   assign halted       = halted_q & ~rst;
   assign alu_op       = rst ? 3'd0 : alu_op_q;
   assign reg_dest     = rst ? 2'd0 : ir_q[3:2];
   assign reg_src1     = ir_q[1] & ~rst;
   assign reg_src2     = ir_q[0] & ~rst;

`ifdef CPU_SEQ_FETCH_TIMEOUT_EN
   assign fault = fault_q & ~rst;
`else
   assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus a randomized
// instruction stream, each cycle checked against an instruction-level model.
module tb_cpu_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] instr = 8'h00;
   logic       instr_valid = 1'b0;
   logic       alu_zero = 1'b0;
   logic [7:0] pc;
   logic       instr_req;
   logic [1:0] reg_dest;
   logic       reg_src1;
   logic       reg_src2;
   logic       write_enable;
   logic [2:0] alu_op;
   logic       halted;
   logic       fault;

   always #5 clk = ~clk;

   cpu_sequencer #(.FETCH_TIMEOUT(15)) dut (
      .clk          (clk),
      .rst          (rst),
      .instr        (instr),
      .instr_valid  (instr_valid),
      .alu_zero     (alu_zero),
      .pc           (pc),
      .instr_req    (instr_req),
      .reg_dest     (reg_dest),
      .reg_src1     (reg_src1),
      .reg_src2     (reg_src2),
      .write_enable (write_enable),
      .alu_op       (alu_op),
      .halted       (halted),
      .fault        (fault)
   );

   int n_checks = 0;
   int n_errors = 0;
   int model_pc = 0;
   int alu_tbl[16];  // ALU select per opcode, -1 for non-ALU opcodes

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_ctrl(input string tag, input logic req, input logic we,
                             input logic hlt, input logic flt);
      check_eq({tag, ".instr_req"}, 32'(instr_req), 32'(req));
      check_eq({tag, ".write_enable"}, 32'(write_enable), 32'(we));
      check_eq({tag, ".halted"}, 32'(halted), 32'(hlt));
      check_eq({tag, ".fault"}, 32'(fault), 32'(flt));
   endtask

   // Advance to just after the next rising edge; reset defaults low.
   task automatic next_cycle();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic do_reset();
      next_cycle();
      rst = 1'b1;
      instr_valid = 1'($urandom);
      #3;
      check_ctrl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("reset.alu_op", 32'(alu_op), 32'd0);
      check_eq("reset.reg", {29'd0, reg_dest, reg_src1}, 32'd0);
      check_eq("reset.reg_src2", 32'(reg_src2), 32'd0);
      model_pc = 0;
   endtask

   // Run one instruction starting at a FETCH cycle. waits = cycles with
   // instr_valid low before the handshake.
   task automatic run_instr(input logic [7:0] ins, input int waits, input logic az,
                            input bit rst_in_wb);
      int op;
      int exp_alu;
      int soff;
      op      = int'(ins[7:4]);
      exp_alu = (alu_tbl[op] < 0) ? 0 : alu_tbl[op];
      for (int i = 0; i < waits; i++) begin
         next_cycle();
         instr_valid = 1'b0;
         instr = 8'($urandom);
         alu_zero = 1'($urandom);
         #3;
         check_ctrl("fetch_wait", 1'b1, 1'b0, 1'b0, 1'b0);
         check_eq("fetch_wait.pc", 32'(pc), 32'(model_pc));
      end
      next_cycle();
      instr_valid = 1'b1;
      instr = ins;
      #3;
      check_ctrl("fetch", 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("fetch.pc", 32'(pc), 32'(model_pc));
      check_eq("fetch.alu_op", 32'(alu_op), 32'd0);

      next_cycle();  // DECODE; stray handshakes must be ignored
      instr_valid = 1'($urandom);
      instr = 8'($urandom);
      #3;
      check_ctrl("decode", 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("decode.alu_op", 32'(alu_op), 32'(exp_alu));
      check_eq("decode.reg_dest", 32'(reg_dest), 32'(ins[3:2]));
      check_eq("decode.reg_src1", 32'(reg_src1), 32'(ins[1]));
      check_eq("decode.reg_src2", 32'(reg_src2), 32'(ins[0]));

      next_cycle();  // EXECUTE
      instr_valid = 1'($urandom);
      alu_zero = az;
      #3;
      check_ctrl("execute", 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("execute.alu_op", 32'(alu_op), 32'(exp_alu));

      if (op == 15) begin
         for (int i = 0; i < 20; i++) begin
            next_cycle();
            instr_valid = 1'($urandom);
            alu_zero = 1'($urandom);
            #3;
            check_ctrl("halt", 1'b0, 1'b0, 1'b1, 1'b0);
            check_eq("halt.alu_op", 32'(alu_op), 32'd0);
            check_eq("halt.pc", 32'(pc), 32'(model_pc));
         end
         do_reset();
         return;
      end

      next_cycle();  // WRITEBACK
      instr_valid = 1'($urandom);
      alu_zero = 1'($urandom);
      if (rst_in_wb) begin
         rst = 1'b1;
         #3;
         check_ctrl("wb_rst", 1'b0, 1'b0, 1'b0, 1'b0);
         check_eq("wb_rst.alu_op", 32'(alu_op), 32'd0);
         model_pc = 0;
         return;
      end
      #3;
      check_ctrl("wb", 1'b0, 1'(alu_tbl[op] >= 0), 1'b0, 1'b0);
      check_eq("wb.alu_op", 32'(alu_op), 32'(exp_alu));
      check_eq("wb.pc", 32'(pc), 32'(model_pc));

      if (op == 8 && az) begin
         soff = (ins[3:0] >= 4'd8) ? int'(ins[3:0]) - 16 : int'(ins[3:0]);
         model_pc = (model_pc + soff + 256) % 256;
      end else begin
         model_pc = (model_pc + 1) % 256;
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) alu_tbl[i] = -1;
      alu_tbl[1] = 0;
      alu_tbl[2] = 1;
      alu_tbl[3] = 2;
      alu_tbl[4] = 3;
      alu_tbl[5] = 4;
      alu_tbl[6] = 5;

      do_reset();
      run_instr(8'h14, 0, 1'b0, 1'b0);   // ADD: write in cycle 4
      run_instr(8'h00, 3, 1'b1, 1'b0);   // NOP after 3 wait cycles
      run_instr(8'h8D, 0, 1'b1, 1'b0);   // BZ -3 taken from 0x02 -> 0xFF
      run_instr(8'h00, 1, 1'b0, 1'b0);   // NOP wraps 0xFF -> 0x00
      next_cycle();
      instr_valid = 1'b0;
      #3;
      check_eq("wrap.pc", 32'(pc), 32'h00);

      do_reset();
      run_instr(8'h00, 0, 1'b0, 1'b0);
      run_instr(8'h00, 0, 1'b0, 1'b0);
      run_instr(8'h8D, 0, 1'b0, 1'b0);   // BZ not taken -> 0x03
      next_cycle();
      instr_valid = 1'b0;
      #3;
      check_eq("bz_not_taken.pc", 32'(pc), 32'h03);

      // Random stream; HALT excluded here, exercised separately.
      for (int n = 0; n < 150; n++) begin
         logic [7:0] ins;
         ins = 8'($urandom);
         if (ins[7:4] == 4'hF) ins[7:4] = 4'h8;
         run_instr(ins, int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
      end

      run_instr(8'h64, 1, 1'b0, 1'b1);   // MOV with reset in WRITEBACK
      run_instr(8'h25, 0, 1'b1, 1'b0);   // core restarts from pc 0
      run_instr(8'hF0, 2, 1'b0, 1'b0);   // HALT, 20 cycles, then reset
      run_instr(8'h39, 0, 1'b0, 1'b0);

`ifdef CPU_SEQ_FETCH_TIMEOUT_EN
      for (int i = 0; i < 15; i++) begin
         next_cycle();
         instr_valid = 1'b0;
         #3;
         check_ctrl("timeout_wait", 1'b1, 1'b0, 1'b0, 1'b0);
      end
      for (int i = 0; i < 5; i++) begin
         next_cycle();
         instr_valid = 1'($urandom);
         #3;
         check_ctrl("fault", 1'b0, 1'b0, 1'b1, 1'b1);
      end
      do_reset();
`else
      for (int i = 0; i < 30; i++) begin
         next_cycle();
         instr_valid = 1'b0;
         #3;
         check_ctrl("long_wait", 1'b1, 1'b0, 1'b0, 1'b0);
      end
`endif
      run_instr(8'h1B, 0, 1'b0, 1'b0);
      next_cycle();
      instr_valid = 1'b0;
      #3;
      check_ctrl("final_fetch", 1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("final_fetch.pc", 32'(pc), 32'(model_pc));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
